upg_boot_ctrl: RTL

Boot/programming sequencer and memory-write arbiter for the single-cycle MIPS core. It debounces the start-programming button and holds the CPU in reset while the UART programmer loads the program ROM and data RAM. It steers UART writes to ROM or RAM by address bit 14 and releases the CPU after programming completes. During normal run it passes CPU data-memory writes through and masks all UART writes.

---
 rtl/upg_boot_ctrl_if.sv | 28 ++
 rtl/upg_boot_ctrl.sv | 73 +++++++
 2 files changed

// File: rtl/upg_boot_ctrl_if.sv
// upg_boot_ctrl_if: programmer, CPU and memory-write signals of the boot sequencer.
interface upg_boot_ctrl_if;
  logic        start_pg;
  logic        upg_wen_i;
  logic [14:0] upg_adr_i;
  logic [31:0] upg_dat_i;
  logic        upg_done_i;
  logic        cpu_mem_wen_i;
  logic [31:0] cpu_adr_i;
  logic [31:0] cpu_dat_i;
  logic        rom_wen_o;
  logic        ram_wen_o;
  logic [31:0] mem_adr_o;
  logic [31:0] mem_dat_o;
  logic        upg_rst_o;
  logic        cpu_rst_o;
  logic [1:0]  mode_o;
  logic [15:0] prog_words_o;
  logic        err_o;
  modport master (
    output start_pg, upg_wen_i, upg_adr_i, upg_dat_i, upg_done_i, cpu_mem_wen_i, cpu_adr_i, cpu_dat_i,
    input  rom_wen_o, ram_wen_o, mem_adr_o, mem_dat_o, upg_rst_o, cpu_rst_o, mode_o, prog_words_o, err_o
  );
  modport slave (
    input  start_pg, upg_wen_i, upg_adr_i, upg_dat_i, upg_done_i, cpu_mem_wen_i, cpu_adr_i, cpu_dat_i,
    output rom_wen_o, ram_wen_o, mem_adr_o, mem_dat_o, upg_rst_o, cpu_rst_o, mode_o, prog_words_o, err_o
  );
endinterface

// File: rtl/upg_boot_ctrl.sv
// upg_boot_ctrl: debounced programming sequencer that holds the CPU in reset
// while the UART programmer writes ROM/RAM, and arbitrates memory writes.
module upg_boot_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int RELEASE_DELAY   = 8,
  parameter int TIMEOUT         = 1024
) (
  input logic clock,
  input logic reset,
  upg_boot_ctrl_if.slave bus
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(RELEASE_DELAY + 1);
  typedef enum logic [2:0] {RUN, ARM, PROG, DRAIN, ERR} state_t;
  state_t state, nxt;
  logic [1:0]  sync;
  logic [DW-1:0] deb;
  logic [IW-1:0] idle;
  logic [RW-1:0] drain;
  logic        upg_rst, cpu_rst, err;
  logic [15:0] words;
  logic        evt, prog, run;
  // The counter saturates, so a held button yields exactly one event.
  assign evt  = sync[1] && deb == DW'(DEBOUNCE_CYCLES - 1);
  assign prog = state == PROG;
  assign run  = state == RUN;
  always_comb begin
    nxt = state;
    case (state)
      RUN:   nxt = evt ? ARM : RUN;
      ARM:   nxt = bus.upg_done_i ? ARM : PROG;
      PROG:  nxt = bus.upg_done_i ? DRAIN :
                   (!bus.upg_wen_i && idle == IW'(TIMEOUT - 1)) ? ERR : PROG;
      DRAIN: nxt = drain == RW'(RELEASE_DELAY - 1) ? RUN : DRAIN;
      ERR:   nxt = evt ? ARM : ERR;
      default: nxt = RUN;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= RUN;
      sync    <= '0;
      deb     <= '0;
      idle    <= '0;
      drain   <= '0;
      upg_rst <= 1'b1;
      cpu_rst <= 1'b1;
      err     <= 1'b0;
      words   <= '0;
    end else begin
      state   <= nxt;
      sync    <= {sync[0], bus.start_pg};
      deb     <= !sync[1] ? '0 : (deb == DW'(DEBOUNCE_CYCLES) ? deb : deb + 1'b1);
      idle    <= (prog && !bus.upg_wen_i) ? idle + 1'b1 : '0;
      drain   <= state == DRAIN ? drain + 1'b1 : '0;
      upg_rst <= run || state == ERR;
      cpu_rst <= !run;
      err     <= state == ERR;
      words   <= state == ARM ? '0 :
                 (prog && bus.upg_wen_i && words != 16'hFFFF) ? words + 1'b1 : words;
    end
  end
  assign bus.rom_wen_o    = prog & bus.upg_wen_i & ~bus.upg_adr_i[14];
  assign bus.ram_wen_o    = prog ? bus.upg_wen_i & bus.upg_adr_i[14] : run & bus.cpu_mem_wen_i;
  assign bus.mem_adr_o    = prog ? {16'b0, bus.upg_adr_i[13:0], 2'b00} : bus.cpu_adr_i;
  assign bus.mem_dat_o    = prog ? bus.upg_dat_i : bus.cpu_dat_i;
  assign bus.mode_o       = run ? 2'd0 : state == ARM ? 2'd1 : prog ? 2'd2 : 2'd3;
  assign bus.upg_rst_o    = upg_rst;
  assign bus.cpu_rst_o    = cpu_rst;
  assign bus.err_o        = err;
  assign bus.prog_words_o = words;
endmodule
